// File: rtl/fetch.sv
// fetch: PC generation, instruction memory requests and a 2-entry in-order buffer to decode.
module fetch #(
  parameter int data_width = 32,
  parameter logic [data_width-1:0] RESET_PC = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  imem_req_valid,
  output logic [data_width-1:0] imem_req_addr,
  input  logic                  imem_req_ready,
  input  logic                  imem_rsp_valid,
  input  logic [data_width-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [data_width-1:0] redirect_pc,
  input  logic                  stall_decode,
  output logic [data_width-1:0] instr_reg_fetch,
  output logic [data_width-1:0] pc_fetch,
  output logic [data_width-1:0] npc_fetch,
  output logic                  fetch_valid
);
  logic [data_width-1:0] r_pc;
  logic [data_width-1:0] r_ins [2];
  logic [data_width-1:0] r_pcs [2];
  logic [1:0] r_out, r_cnt;
  logic [3:0] r_drop;
  logic r_head;
  logic w_acc, w_skip, w_take, w_push, w_pop, w_tail;
  logic [data_width-1:0] w_rsp_pc;
  assign imem_req_valid = !rst && !redirect_valid && (3'(r_out) + 3'(r_cnt) < 3'd2);
  assign imem_req_addr = r_pc;
  assign w_acc = imem_req_valid & imem_req_ready;
  assign w_skip = imem_rsp_valid & (r_drop != 4'd0);
  assign w_take = imem_rsp_valid & (r_drop == 4'd0) & (r_out != 2'd0);
  assign w_push = w_take & ~redirect_valid;
  assign fetch_valid = !rst && (r_cnt != 2'd0);
  assign w_pop = fetch_valid & ~stall_decode;
  assign w_tail = r_head ^ r_cnt[0];
  // responses return in order, so the oldest outstanding request sits r_out words behind the PC
  assign w_rsp_pc = r_pc - (data_width'(r_out) << 2);
  assign instr_reg_fetch = fetch_valid ? r_ins[r_head] : '0;
  assign pc_fetch = fetch_valid ? r_pcs[r_head] : '0;
  assign npc_fetch = fetch_valid ? r_pcs[r_head] + data_width'(4) : '0;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc <= RESET_PC & ~data_width'(3);
      r_out <= '0;
      r_cnt <= '0;
      r_drop <= '0;
      r_head <= 1'b0;
    end else if (redirect_valid) begin
      r_pc <= redirect_pc & ~data_width'(3);
      r_out <= '0;
      r_cnt <= '0;
      r_drop <= r_drop - 4'(w_skip) + 4'(r_out) - 4'(w_take);
    end else begin
      if (w_acc) r_pc <= r_pc + data_width'(4);
      r_out <= r_out + 2'(w_acc) - 2'(w_take);
      r_drop <= r_drop - 4'(w_skip);
      r_cnt <= r_cnt + 2'(w_push) - 2'(w_pop);
      if (w_pop) r_head <= ~r_head;
      if (w_push) begin
        r_ins[w_tail] <= imem_rsp_data;
        r_pcs[w_tail] <= w_rsp_pc;
      end
    end
  end
endmodule

// File: tb/tb_fetch.sv
// tb_fetch: randomized fetch-unit bench with a memory model and an in-order decode-stream scoreboard.
module tb_fetch;
  localparam logic [31:0] RST_PC = 32'h0;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic stall_decode = 1'b0;
  logic [31:0] instr_reg_fetch, pc_fetch, npc_fetch;
  logic fetch_valid;
  fetch dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall_decode(stall_decode),
    .instr_reg_fetch(instr_reg_fetch), .pc_fetch(pc_fetch), .npc_fetch(npc_fetch), .fetch_valid(fetch_valid)
  );
  always #5 clk = ~clk;
  int n_chk = 0, n_fail = 0, cyc = 0, lat_min = 1, lat_max = 1, pops = 0, live = 0;
  logic [31:0] mq_addr[$];
  int mq_due[$];
  logic [31:0] popped[$];
  logic [31:0] exp_pc = RST_PC, exp_req = RST_PC, prev_addr = '0;
  bit prev_hold = 0;
  function automatic logic [31:0] f(input logic [31:0] a);
    return a == 32'h8 ? 32'h0000_0013 : (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction
  task automatic cycle(input bit rdy, input bit stl, input bit rdr, input logic [31:0] rpc, input bit rs);
    @(posedge clk); #1;
    rst = rs; imem_req_ready = rdy; stall_decode = stl; redirect_valid = rdr; redirect_pc = rpc;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1; imem_rsp_data = f(mq_addr[0]);
      void'(mq_addr.pop_front()); void'(mq_due.pop_front());
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    end
    @(negedge clk);
    if (rs) begin
      n_chk++;
      if (fetch_valid !== 1'b0 || imem_req_valid !== 1'b0 || instr_reg_fetch !== '0 || pc_fetch !== '0 || npc_fetch !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs: fv=%b rv=%b instr=%h pc=%h npc=%h, required all zero", fetch_valid, imem_req_valid, instr_reg_fetch, pc_fetch, npc_fetch);
      end
    end else begin
      if (prev_hold && !rdr) begin
        n_chk++;
        if (imem_req_valid !== 1'b1 || imem_req_addr !== prev_addr) begin
          n_fail++;
          $display("FAIL req_hold: valid=%b addr=%h, required valid=1 addr=%h", imem_req_valid, imem_req_addr, prev_addr);
        end
      end
      if (imem_req_valid === 1'b1) begin
        n_chk++;
        if (rdr || live >= 2 || imem_req_addr !== exp_req) begin
          n_fail++;
          $display("FAIL request: addr=%h redirect=%b in_flight=%0d, required addr=%h no redirect in_flight<2", imem_req_addr, rdr, live, exp_req);
        end
      end
      if (fetch_valid === 1'b1) begin
        n_chk++;
        if (live == 0 || pc_fetch !== exp_pc || npc_fetch !== exp_pc + 32'd4 || instr_reg_fetch !== f(exp_pc)) begin
          n_fail++;
          $display("FAIL decode_stream: pc=%h npc=%h instr=%h, required pc=%h npc=%h instr=%h", pc_fetch, npc_fetch, instr_reg_fetch, exp_pc, exp_pc + 32'd4, f(exp_pc));
        end
      end
    end
    if (rs) begin
      exp_pc = RST_PC; exp_req = RST_PC; live = 0; prev_hold = 0;
      mq_addr.delete(); mq_due.delete();
    end else if (rdr) begin
      exp_pc = rpc & ~32'd3; exp_req = rpc & ~32'd3; live = 0; prev_hold = 0;
    end else begin
      if (imem_req_valid && rdy) begin
        live++; exp_req += 32'd4;
        mq_addr.push_back(imem_req_addr);
        mq_due.push_back(cyc + lat_min + int'($urandom_range(lat_max - lat_min)));
      end
      if (fetch_valid && !stl) begin
        live--; exp_pc += 32'd4; pops++;
        popped.push_back(pc_fetch);
      end
      prev_hold = imem_req_valid && !rdy;
      prev_addr = imem_req_addr;
    end
    cyc++;
  endtask
  task automatic test_reset();
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0);
    n_chk++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC || fetch_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first_req: valid=%b addr=%h fv=%b, required valid=1 addr=%h fv=0", imem_req_valid, imem_req_addr, fetch_valid, RST_PC);
    end
  endtask
  task automatic test_stream();
    lat_min = 1; lat_max = 1;
    cycle(1, 0, 0, 0, 1);
    popped.delete();
    repeat (12) cycle(1, 0, 0, 0, 0);
    n_chk++;
    if (popped.size() < 4 || popped[0] !== 32'h0 || popped[1] !== 32'h4 || popped[2] !== 32'h8) begin
      n_fail++;
      $display("FAIL stream_order: got %0d pops first=%h,%h, required >=4 pops starting 0,4,8", popped.size(),
               popped.size() > 0 ? popped[0] : 32'hDEAD_BEEF, popped.size() > 1 ? popped[1] : 32'hDEAD_BEEF);
    end
  endtask
  task automatic test_stall();
    bit seen;
    lat_min = 1; lat_max = 1;
    cycle(1, 0, 0, 0, 1);
    seen = 0;
    for (int i = 0; i < 30 && !seen; i++) begin
      cycle(1, 0, 0, 0, 0);
      seen = fetch_valid && pc_fetch == 32'h4;
    end
    seen = 0;
    for (int i = 0; i < 10 && !seen; i++) begin
      cycle(1, 1, 0, 0, 0);
      seen = fetch_valid && pc_fetch == 32'h8;
    end
    for (int i = 0; i < 4; i++) begin
      cycle(1, 1, 0, 0, 0);
      n_chk++;
      if (fetch_valid !== 1'b1 || pc_fetch !== 32'h8 || instr_reg_fetch !== 32'h13 || (i > 0 && imem_req_valid !== 1'b0)) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: fv=%b pc=%h instr=%h req=%b, required fv=1 pc=8 instr=13 no request when full", i, fetch_valid, pc_fetch, instr_reg_fetch, imem_req_valid);
      end
    end
    popped.delete();
    repeat (8) cycle(1, 0, 0, 0, 0);
    n_chk++;
    if (popped.size() < 3 || popped[0] !== 32'h8 || popped[1] !== 32'hC || popped[2] !== 32'h10) begin
      n_fail++;
      $display("FAIL stall_resume: got %0d pops first=%h, required 8,C,10", popped.size(), popped.size() > 0 ? popped[0] : 32'hDEAD_BEEF);
    end
  endtask
  task automatic test_redirect();
    bit seen;
    lat_min = 3; lat_max = 3;
    cycle(1, 0, 0, 0, 1);
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1, 0, 0, 0, 0);
      seen = mq_addr.size() == 2;
    end
    cycle(1, 0, 1, 32'h0000_0102, 0);
    n_chk++;
    if (imem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL redirect_no_req: valid=%b, required 0", imem_req_valid);
    end
    cycle(1, 0, 0, 0, 0);
    n_chk++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL redirect_first_req: valid=%b addr=%h, required 1 and 100", imem_req_valid, imem_req_addr);
    end
    seen = fetch_valid;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1, 0, 0, 0, 0);
      seen = fetch_valid;
    end
    n_chk++;
    if (!seen || pc_fetch !== 32'h100 || npc_fetch !== 32'h104) begin
      n_fail++;
      $display("FAIL redirect_first_out: fv=%b pc=%h npc=%h, required pc=100 npc=104", fetch_valid, pc_fetch, npc_fetch);
    end
  endtask
  task automatic test_wrap();
    bit seen;
    lat_min = 1; lat_max = 1;
    cycle(1, 0, 1, 32'hFFFF_FFFC, 0);
    cycle(1, 0, 0, 0, 0);
    n_chk++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
      n_fail++;
      $display("FAIL wrap_req0: valid=%b addr=%h, required 1 and FFFFFFFC", imem_req_valid, imem_req_addr);
    end
    cycle(1, 0, 0, 0, 0);
    n_chk++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_req1: valid=%b addr=%h, required 1 and 0", imem_req_valid, imem_req_addr);
    end
    seen = fetch_valid;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1, 1, 0, 0, 0);
      seen = fetch_valid;
    end
    n_chk++;
    if (!seen || pc_fetch !== 32'hFFFF_FFFC || npc_fetch !== 32'h0) begin
      n_fail++;
      $display("FAIL wrap_npc: fv=%b pc=%h npc=%h, required pc=FFFFFFFC npc=0", fetch_valid, pc_fetch, npc_fetch);
    end
  endtask
  task automatic test_not_ready();
    cycle(0, 0, 1, 32'h0000_0200, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 0, 0);
      n_chk++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h200) begin
        n_fail++;
        $display("FAIL not_ready[%0d]: valid=%b addr=%h, required 1 and 200", i, imem_req_valid, imem_req_addr);
      end
    end
    cycle(1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0);
    n_chk++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h204) begin
      n_fail++;
      $display("FAIL ready_advance: valid=%b addr=%h, required 1 and 204", imem_req_valid, imem_req_addr);
    end
  endtask
  task automatic test_reset_mid();
    bit seen;
    lat_min = 3; lat_max = 3;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle(1, 0, 0, 0, 0);
      seen = mq_addr.size() == 2 && live == 2;
    end
    cycle(1, 0, 0, 0, 1);
    cycle(1, 0, 0, 0, 0);
    n_chk++;
    if (fetch_valid !== 1'b0 || instr_reg_fetch !== '0 || pc_fetch !== '0 || npc_fetch !== '0 ||
        imem_req_valid !== 1'b1 || imem_req_addr !== RST_PC) begin
      n_fail++;
      $display("FAIL reset_mid: fv=%b instr=%h pc=%h npc=%h req=%b addr=%h, required zeros and request at %h",
               fetch_valid, instr_reg_fetch, pc_fetch, npc_fetch, imem_req_valid, imem_req_addr, RST_PC);
    end
  endtask
  task automatic test_random();
    int p0;
    p0 = pops;
    lat_min = 1; lat_max = 3;
    for (int i = 0; i < 800; i++)
      cycle($urandom_range(3) != 0, $urandom_range(2) == 0, $urandom_range(19) == 0, $urandom, $urandom_range(99) == 0);
    n_chk++;
    if (pops - p0 < 50) begin
      n_fail++;
      $display("FAIL random_progress: %0d instructions delivered, required at least 50", pops - p0);
    end
  endtask
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_wrap();
    test_not_ready();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
